dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sequences every access to the single-port data memory behind the MEM stage.
- Arbitrates between the pipeline MEM-stage request and a secondary debug/loader port.
- Drives the memory strobes for a fixed multi-cycle access window and returns read data.
- Raises a freeze to the pipeline until the pipeline's own access completes.

Parameters:
- WAIT_CYCLES, 4, cycles the memory strobes are held per access (legal range 1..15).
- BASE_ADDR, 1024, byte address mapped to memory word 0.
- ADDR_W, 6, memory word-address width (64 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pipe_r_en  in  1  MEM-stage load request.
- pipe_w_en  in  1  MEM-stage store request.
- pipe_addr  in  32  byte address (ALU result).
- pipe_wdata  in  32  store data (Rm value).
- pipe_rdata  out  32  load result, valid while pipe_ack=1.
- pipe_ack  out  1  pipeline access complete (one-cycle pulse).
- freeze  out  1  stall request to all pipeline registers.
- dbg_req  in  1  debug-port request, held until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  32  byte address.
- dbg_wdata  in  32  debug write data.
- dbg_rdata  out  32  debug read result, valid while dbg_ack=1.
- dbg_ack  out  1  debug access complete (one-cycle pulse).
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  32  memory read data, valid on the last strobe cycle.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all outputs 0, counter 0, fairness bit=pipeline-first. A pending access is abandoned without an ack.
- Requester accepts a request when pipe_r_en|pipe_w_en or dbg_req is high. Requesters hold address, data and type stable until their ack.
- States:
  - IDLE: if any request is pending, grant, register the request (addr, wdata, type, owner), set counter=WAIT_CYCLES-1 and go to ACCESS. Otherwise stay.
  - ACCESS: drive mem_addr, mem_wdata, and mem_we or mem_re from the registered request. If counter=0, capture mem_rdata (reads only) and go to DONE. Otherwise decrement the counter.
  - DONE: pulse the owner's ack with registered rdata. Strobes are 0. Go to IDLE. No grant is made in DONE.
- Arbitration:
  - If only one requester is pending, grant it.
  - If both are pending, grant the owner named by the fairness bit.
  - The fairness bit flips to the other requester after each grant made while both were pending. Neither requester waits more than one foreign access.
- Pipeline request type: if pipe_w_en and pipe_r_en are both high, the access is a write.
- Address mapping: mem_addr = ((addr - BASE_ADDR) >> 2) truncated to ADDR_W bits (modular wrap). The low two address bits are ignored.
- freeze = (pipe_r_en|pipe_w_en) & ~pipe_ack, combinational. Freeze drops exactly in the DONE cycle, so the pipeline advances on that edge.
- Latency: uncontended pipeline access gives ack in cycle WAIT_CYCLES+1 after the request cycle. Total freeze is WAIT_CYCLES+1 cycles.
- Write acks: pipe_rdata/dbg_rdata are 0 on write acks and whenever the ack is low.
- A request dropped before its grant is simply not served. A request dropped after its grant still completes, and its ack is ignored.
- A new request presented during DONE is granted in the following IDLE cycle.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: rst=0 in ACCESS cycle 2.
  - Required: strobes and acks drop immediately, no ack ever issues, and the next request after release behaves normally.
- Pipeline store then load at default parameters:
  - Stimulus: pipe_w_en, addr 1028, data 0xDEADBEEF.
  - Required: mem_addr=1 with mem_we high for 4 cycles, freeze high for 5 cycles, then pipe_ack.
  - Stimulus: follow with a load from 1028.
  - Required: pipe_rdata=0xDEADBEEF with pipe_ack.
- Contention fairness:
  - Stimulus: pipeline and debug both request continuously.
  - Required: grants alternate pipe, dbg, pipe, dbg, and each ack goes to the correct port.
- Address wrap:
  - Stimulus: load from addr 1024+256.
  - Required: mem_addr=0.
  - Stimulus: addr 1022.
  - Required: mem_addr=63.
- Simultaneous pipe_r_en and pipe_w_en:
  - Required: write performed (mem_we high, mem_re low), pipe_rdata=0 at ack.
- WAIT_CYCLES=1 build:
  - Stimulus: back-to-back pipeline loads.
  - Required: ack every 3 cycles and freeze high for 2 cycles per access.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Bus bundle between the data-memory access controller, its two requesters
// (MEM stage, debug/loader port) and the single-port data memory.
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              pipe_r_en;
    logic              pipe_w_en;
    logic [31:0]       pipe_addr;
    logic [31:0]       pipe_wdata;
    logic [31:0]       pipe_rdata;
    logic              pipe_ack;
    logic              freeze;

    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    // The controller side.
    modport slave (
        input  pipe_r_en, pipe_w_en, pipe_addr, pipe_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output pipe_rdata, pipe_ack, freeze,
        output dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    // The requesters and the memory together.
    modport master (
        output pipe_r_en, pipe_w_en, pipe_addr, pipe_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  pipe_rdata, pipe_ack, freeze,
        input  dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences fixed-length accesses to the single-port data memory, arbitrating
// fairly between the MEM stage and the debug/loader port, and freezes the pipe.
module dmem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic                clk,
    input  logic                rst,
    dmem_access_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_PIPE, OWN_DBG} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    owner_t      owner;
    owner_t      fair;
    logic [3:0]  cnt;

    logic        pipe_req;
    logic        grant_dbg;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return ADDR_W'((byte_addr - BASE_ADDR) >> 2);
    endfunction

    assign pipe_req  = bus.pipe_r_en | bus.pipe_w_en;
    // Debug wins when it is alone, or when both are pending and it is debug's turn.
    assign grant_dbg = bus.dbg_req & (~pipe_req | (fair == OWN_DBG));
    assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.pipe_addr;
    assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.pipe_wdata;
    assign sel_we    = grant_dbg ? bus.dbg_we    : bus.pipe_w_en;

    // Freeze releases in the DONE cycle so the pipeline advances on that edge.
    assign bus.freeze = pipe_req & ~bus.pipe_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= OWN_PIPE;
            fair           <= OWN_PIPE;
            cnt            <= '0;
            bus.pipe_ack   <= 1'b0;
            bus.pipe_rdata <= '0;
            bus.dbg_ack    <= 1'b0;
            bus.dbg_rdata  <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_re     <= 1'b0;
        end else begin
            // NOTE: acks and their data default low every cycle, so they pulse
            // for exactly the one DONE cycle and read zero otherwise.
            bus.pipe_ack   <= 1'b0;
            bus.pipe_rdata <= '0;
            bus.dbg_ack    <= 1'b0;
            bus.dbg_rdata  <= '0;

            unique case (state)
                IDLE: begin
                    if (pipe_req || bus.dbg_req) begin
                        owner         <= grant_dbg ? OWN_DBG : OWN_PIPE;
                        if (pipe_req && bus.dbg_req)
                            fair <= grant_dbg ? OWN_PIPE : OWN_DBG;
                        cnt           <= CNT_INIT;
                        bus.mem_addr  <= word_addr(sel_addr);
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_we    <= sel_we;
                        bus.mem_re    <= ~sel_we;
                        state         <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (owner == OWN_PIPE) begin
                            bus.pipe_ack   <= 1'b1;
                            bus.pipe_rdata <= bus.mem_re ? bus.mem_rdata : '0;
                        end else begin
                            bus.dbg_ack    <= 1'b1;
                            bus.dbg_rdata  <= bus.mem_re ? bus.mem_rdata : '0;
                        end
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_re    <= 1'b0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
